// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and the GF(2^8) / byte-permutation helpers
// used by the inverse cipher.
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } aes_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Byte i lives at bits [127-8i -: 8], i = col*4 + row; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (c * 4 + r) -: 8] = s[127 - 8 * ((((c - r) + 4) % 4) * 4 + r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Four parallel inverse S-box ROMs substituting every byte of one 32-bit word.
module aes_inv_sbox (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    for (genvar i = 0; i < 4; i++) begin : g_rom
        assign word_out[31 - 8 * i -: 8] = INV_SBOX[word_in[31 - 8 * i -: 8]];
    end

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys consumed
// from round_key_10 down to round_key_0.
module aes_decipher_block #(
    parameter int NR = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                key_ready,
    input  logic [127:0]        round_key_0,
    input  logic [127:0]        round_key_1,
    input  logic [127:0]        round_key_2,
    input  logic [127:0]        round_key_3,
    input  logic [127:0]        round_key_4,
    input  logic [127:0]        round_key_5,
    input  logic [127:0]        round_key_6,
    input  logic [127:0]        round_key_7,
    input  logic [127:0]        round_key_8,
    input  logic [127:0]        round_key_9,
    input  logic [127:0]        round_key_10,
    input  logic                start,
    input  logic [127:0]        block_in,
    output logic [127:0]        block_out,
    output logic                valid,
    output logic                busy,
    output aes_pkg::aes_state_e dbg_state
);

    import aes_pkg::*;

    // Handshake: start is accepted only in IDLE with key_ready high; valid then
    // drops on that edge and rises with the result, holding until the next accept.

    aes_state_e   state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_reg_q, state_reg_d;
    logic [127:0] block_out_q, block_out_d;
    logic         valid_q, valid_d;

    logic [127:0] shifted, subbed, rk_sel, added, mixed;

    function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
                gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
                gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
                gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)};
    endfunction

    assign shifted = inv_shift_rows(state_reg_q);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_inv_sbox u_inv_sbox (
            .word_in  (shifted[127 - 32 * i -: 32]),
            .word_out (subbed[127 - 32 * i -: 32])
        );
    end

    // FINAL reuses the same AddRoundKey XOR with the cipher key.
    always_comb begin
        rk_sel = '0;
        if (state_q == FINAL) begin
            rk_sel = round_key_0;
        end else begin
            case (round_q)
                4'd1:    rk_sel = round_key_1;
                4'd2:    rk_sel = round_key_2;
                4'd3:    rk_sel = round_key_3;
                4'd4:    rk_sel = round_key_4;
                4'd5:    rk_sel = round_key_5;
                4'd6:    rk_sel = round_key_6;
                4'd7:    rk_sel = round_key_7;
                4'd8:    rk_sel = round_key_8;
                4'd9:    rk_sel = round_key_9;
                default: rk_sel = '0;
            endcase
        end
    end

    assign added = subbed ^ rk_sel;

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mixed[127 - 32 * c -: 32] = inv_mix_column(added[127 - 32 * c -: 32]);
    end

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        state_reg_d = state_reg_q;
        block_out_d = block_out_q;
        valid_d     = valid_q;
        case (state_q)
            IDLE: begin
                if (start && key_ready) begin
                    state_reg_d = block_in ^ round_key_10;
                    round_d     = 4'(NR - 1);
                    valid_d     = 1'b0;
                    state_d     = ROUND;
                end
            end
            ROUND: begin
                // Keys going invalid mid-block abandon it; block_out keeps the old result.
                if (!key_ready) begin
                    state_d = IDLE;
                end else begin
                    state_reg_d = mixed;
                    if (round_q == 4'd1) begin
                        state_d = FINAL;
                    end else begin
                        round_d = round_q - 4'd1;
                    end
                end
            end
            FINAL: begin
                state_d = IDLE;
                if (key_ready) begin
                    block_out_d = added;
                    valid_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            round_q     <= 4'd0;
            state_reg_q <= '0;
            block_out_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            state_reg_q <= state_reg_d;
            block_out_q <= block_out_d;
            valid_q     <= valid_d;
        end
    end

    assign block_out = block_out_q;
    assign valid     = valid_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Directed-vector bench for aes_decipher_block using the FIPS-197 C.1 and
// Appendix B key schedules and blocks.
module tb_aes_decipher_block;

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk;
    logic         reset_n;
    logic         key_ready;
    logic [127:0] rk [0:10];
    logic         start;
    logic [127:0] block_in;
    logic [127:0] block_out;
    logic         valid;
    logic         busy;
    aes_pkg::aes_state_e dbg_state;

    logic [127:0] exp_q[$];
    int n_cmp;
    int n_bad;

    aes_decipher_block #(.NR(10)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_ready    (key_ready),
        .round_key_0  (rk[0]),
        .round_key_1  (rk[1]),
        .round_key_2  (rk[2]),
        .round_key_3  (rk[3]),
        .round_key_4  (rk[4]),
        .round_key_5  (rk[5]),
        .round_key_6  (rk[6]),
        .round_key_7  (rk[7]),
        .round_key_8  (rk[8]),
        .round_key_9  (rk[9]),
        .round_key_10 (rk[10]),
        .start        (start),
        .block_in     (block_in),
        .block_out    (block_out),
        .valid        (valid),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_c1_keys();
        rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    endtask

    task automatic load_b_keys();
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    endtask

    // Drives one start, counts edges until valid (bounded), then scores the result.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt,
                             input bit pulse_busy, input string tag);
        int edges;
        logic [127:0] exp;
        exp_q.push_back(pt);
        start    = 1'b1;
        block_in = ct;
        @(posedge clk);
        #1;
        start    = 1'b0;
        block_in = {4{$urandom}};
        edges    = 0;
        while (edges < 20) begin
            @(negedge clk);
            if (valid) break;
            if (edges == 5) check({tag, " busy mid"}, 128'(busy), 128'd1);
            start    = pulse_busy && (edges == 3 || edges == 6);
            block_in = {4{$urandom}};
            @(posedge clk);
            edges++;
        end
        start = 1'b0;
        exp = exp_q.pop_front();
        check({tag, " latency"}, 128'(edges), 128'd10);
        check({tag, " block_out"}, block_out, exp);
        check({tag, " busy end"}, 128'(busy), 128'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        key_ready = 1'b0;
        start     = 1'b0;
        block_in  = '0;
        load_c1_keys();
        repeat (3) @(posedge clk);
        #1;
        check("reset block_out", block_out, 128'd0);
        check("reset valid", 128'(valid), 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset state", 128'(dbg_state), 128'(aes_pkg::IDLE));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 C.1, then back-to-back in the valid cycle
        key_ready = 1'b1;
        run_block(C1_CT, C1_PT, 1'b0, "c1");
        run_block(C1_CT, C1_PT, 1'b0, "c1 b2b");
        run_block(C1_CT, C1_PT, 1'b1, "c1 start while busy");

        // FIPS-197 Appendix B
        load_b_keys();
        @(posedge clk);
        #1;
        run_block(B_CT, B_PT, 1'b0, "appb");

        // key_ready dropped during cycle 5 of a block
        start    = 1'b1;
        block_in = C1_CT;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        key_ready = 1'b0;
        @(posedge clk);
        #1;
        check("abort state", 128'(dbg_state), 128'(aes_pkg::IDLE));
        check("abort busy", 128'(busy), 128'd0);
        check("abort valid", 128'(valid), 128'd0);
        check("abort block_out", block_out, B_PT);

        // start with key_ready low is ignored
        start    = 1'b1;
        block_in = B_CT;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("klow busy", 128'(busy), 128'd0);
        check("klow state", 128'(dbg_state), 128'(aes_pkg::IDLE));
        repeat (3) @(posedge clk);
        #1;
        check("klow valid", 128'(valid), 128'd0);
        check("klow block_out", block_out, B_PT);

        // Asynchronous reset during cycle 4 of a block
        key_ready = 1'b1;
        start     = 1'b1;
        block_in  = B_CT;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async rst block_out", block_out, 128'd0);
        check("async rst valid", 128'(valid), 128'd0);
        check("async rst busy", 128'(busy), 128'd0);
        check("async rst state", 128'(dbg_state), 128'(aes_pkg::IDLE));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_block(B_CT, B_PT, 1'b0, "appb after reset");

        load_c1_keys();
        @(posedge clk);
        #1;
        run_block(C1_CT, C1_PT, 1'b0, "c1 final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
